tstdp_weight_uart_tx: RTL



---
 rtl/tstdp_uart_pkg.sv | 28 ++
 rtl/uart_tx_byte.sv | 131 +++++++++++++
 rtl/tstdp_weight_uart_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tstdp_uart_pkg.sv
// -----------------------------------------------------------------------------
// tstdp_uart_pkg
// Shared definitions for the TSTDP weight-logging UART transmitter:
//   SYNC_BYTE_DFLT  default first byte of every frame
//   FRAME_BYTES     bytes per frame (sync + 4 payload + checksum)
//   tx_state_t      per-byte serializer states
//   frame_checksum  modulo-256 sum of the four payload bytes
// -----------------------------------------------------------------------------
package tstdp_uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;
  localparam int         FRAME_BYTES    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Sum of the four little-endian payload bytes; the sync byte is not included.
  function automatic logic [7:0] frame_checksum(input logic [31:0] w);
    logic [7:0] sum;
    sum = w[7:0] + w[15:8] + w[23:16] + w[31:24];
    return sum;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 serializer for one byte at a time. A byte offered with load_i while idle,
// or during the final cycle of a stop bit, starts its start bit on the very next
// cycle, so back-to-back bytes are sent with no gap.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load_i       data_i holds the next byte to send (accepted in IDLE or at
//                the last stop-bit cycle)
//   data_i       byte to send, LSB first
//   tx_o         registered serial line, idle high
//   done_o       high during the last cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_byte
  import tstdp_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_end_s;

  assign baud_end_s = (baud_q == BAUD_LAST);

  // State register, counters, shifter and the registered serial line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic: each bit holds for exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        baud_d    = '0;
        bit_idx_d = 3'd0;
        if (load_i) begin
          state_d = START;
          shift_d = data_i;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_end_s) begin
          state_d   = DATA;
          baud_d    = '0;
          bit_idx_d = 3'd0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end_s) begin
          baud_d = '0;
          // Chaining the next byte here keeps the inter-byte gap at zero.
          if (load_i) begin
            state_d = START;
            shift_d = data_i;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        baud_d    = '0;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Output decode from the next state so tx_q lines up with the state it shows.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o   = tx_q;
  assign done_o = (state_q == STOP) && baud_end_s;

endmodule

// File: rtl/tstdp_weight_uart_tx.sv
// -----------------------------------------------------------------------------
// tstdp_weight_uart_tx
// Frames one signed 32-bit TSTDP weight sample per handshake as
//   SYNC_BYTE, w[7:0], w[15:8], w[23:16], w[31:24], checksum
// and sends it 8N1 on tx. Sample is taken only on the handshake cycle.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   weight_in     signed weight sample
//   weight_valid  weight_in holds a sample to send
//   weight_ready  block can accept a sample this cycle (= !busy)
//   tx            UART serial line, idle high
//   busy          frame in progress
//   frame_done    one-cycle pulse in the idle cycle after the last stop bit
// -----------------------------------------------------------------------------
module tstdp_weight_uart_tx
  import tstdp_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] weight_in,
  input  logic        weight_valid,
  output logic        weight_ready,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  csum_q, csum_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;

  logic        hs_s;
  logic        load_s;
  logic [7:0]  load_byte_s;
  logic        byte_done_s;

  // Frame byte for a given index; index 0 is the sync byte.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [31:0] w,
                                            input logic [7:0]  cs);
    logic [7:0] b;
    case (idx)
      3'd1:    b = w[7:0];
      3'd2:    b = w[15:8];
      3'd3:    b = w[23:16];
      3'd4:    b = w[31:24];
      3'd5:    b = cs;
      default: b = SYNC_BYTE;
    endcase
    return b;
  endfunction

  assign hs_s = weight_valid && ready_q;

  // Byte sequencer registers and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q   <= 32'd0;
      csum_q     <= 8'd0;
      byte_idx_q <= 3'd0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      csum_q     <= csum_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  // Sequencer: capture on handshake, then feed the next byte as each one ends.
  always_comb begin
    shadow_d    = shadow_q;
    csum_d      = csum_q;
    byte_idx_d  = byte_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_s      = 1'b0;
    load_byte_s = SYNC_BYTE;
    if (hs_s) begin
      shadow_d    = weight_in;
      csum_d      = frame_checksum(weight_in);
      byte_idx_d  = 3'd0;
      busy_d      = 1'b1;
      load_s      = 1'b1;
      load_byte_s = SYNC_BYTE;
    end else if (byte_done_s) begin
      if (byte_idx_q < LAST_BYTE) begin
        byte_idx_d  = byte_idx_q + 3'd1;
        load_s      = 1'b1;
        load_byte_s = frame_byte(byte_idx_q + 3'd1, shadow_q, csum_q);
      end else begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else begin
      load_s = 1'b0;
    end
    ready_d = ~busy_d;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .reset  (reset),
    .load_i (load_s),
    .data_i (load_byte_s),
    .tx_o   (tx),
    .done_o (byte_done_s)
  );

  assign weight_ready = ready_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

endmodule
